trace_stall_sched: RTL and testbench
====================================

// Module: trace_stall_sched
// PURPOSE
//  Sequences the trace datapath between cpu_top and dma_ctrl. Registers the 128-bit trace
//  word, generates dma_we, and throttles the CPU through stall_enable/stall_disable when
//  dma_ctrl reports no space. Replaces the hand-built stall/we glue logic around cpu_top.
// PARAMETERS
//  DATA_W          128  trace word width (iana_out)
//  DRAIN_CYCLES    3    cycles dma_we stays high after the CPU acknowledges a stall
//  RESUME_PULSE    2    width of the stall_disable pulse, in cycles (>=1)
//  RESUME_TIMEOUT  16   cycles to wait for stall release before re-pulsing stall_disable
// PORTS
//  clk                  in   1       CPU clock; all logic on posedge
//  nreset               in   1       asynchronous, active-low reset
//  cpu_reset_in         in   1       cpu_ctrl_in[0]; CPU held in reset
//  trace_fault_in       in   1       cpu_ctrl_in[13]; 1 = lossless mode (stall on full)
//  iana_in              in   DATA_W  trace word from cpu_top
//  is_stall_enabled_in  in   1       CPU stall acknowledge
//  dma_writable_in      in   1       dma_ctrl FIFO has space
//  stall_enable_out     out  1       stall request to cpu_top
//  stall_disable_out    out  1       resume pulse to cpu_top
//  dma_data_out         out  DATA_W  registered trace word to dma_ctrl.dma_in
//  dma_we_out           out  1       write strobe to dma_ctrl
//  state_out            out  3       FSM state, for debug/LED
//  drop_count_out       out  16      saturating count of words lost while FIFO full
//  stall_count_out      out  16      saturating count of stall episodes
// BEHAVIOUR
//  - Reset (nreset=0, asynchronous): all outputs 0, state RUN, counters 0.
//  - Datapath: every cycle, dma_data_out <= iana_in. want_we <= !is_stall_enabled_in
//    OR (state==DRAIN && !cpu_reset_in). Latency from iana_in to dma_data_out is 1 cycle.
//  - dma_we_out = want_we & dma_writable_in. If want_we=1 and dma_writable_in=0, drop the
//    word and increment drop_count (saturates at 16'hFFFF).
//  - FSM (encoding: RUN=0, STALL=1, DRAIN=2, WAIT=3, RESUME=4):
//    RUN:    if trace_fault_in & !dma_writable_in & !cpu_reset_in: go to STALL,
//            stall_enable_out=1, stall_count+1 (saturating).
//    STALL:  hold stall_enable_out=1. Once is_stall_enabled_in=1: go to DRAIN and load
//            drain_cnt=DRAIN_CYCLES.
//    DRAIN:  hold stall_enable_out=1. Decrement drain_cnt; at 0 go to WAIT.
//    WAIT:   hold stall_enable_out=1 until dma_writable_in=1. Then drop stall_enable_out,
//            go to RESUME, load pulse_cnt=RESUME_PULSE.
//    RESUME: stall_disable_out=1 while pulse_cnt>0. After that, when is_stall_enabled_in=0,
//            go to RUN. If it is still 1 after RESUME_TIMEOUT cycles, reload pulse_cnt and
//            re-pulse.
//  - In the RESUME state, stall_enable_out=0. stall_enable_out is never high in the same
//    cycle as stall_disable_out.
//  - trace_fault_in=0: the FSM never leaves RUN (lossy mode). An in-progress episode still
//    completes.
//  - cpu_reset_in=1 in any state: go to RUN next cycle, stall_enable/disable_out=0,
//    drain suppressed. Counters are kept.
//  - dma_writable_in rising during STALL/DRAIN: the sequence still completes in order.
//    RUN is never re-entered without a stall_disable pulse.
//  - Counters clear only on nreset.
// TESTING
//  1 Reset: nreset=0 mid-RESUME -> all outputs 0 at once; after release state_out=0.
//  2 Streaming: is_stall=0, writable=1, iana_in=k per cycle -> dma_we_out=1,
//    dma_data_out=k one cycle later, drop_count=0.
//  3 Backpressure: trace_fault=1, writable falls -> stall_enable next cycle; is_stall=1 at
//    T -> dma_we high through T+3 then low; writable=1 -> 2-cycle stall_disable,
//    stall_count=1.
//  4 Lossy: trace_fault=0, writable=0 for 10 active cycles -> no stall_enable,
//    drop_count=10.
//  5 Timeout: is_stall held 1 after the resume pulse -> second 2-cycle pulse exactly
//    16 cycles later.
//  6 CPU reset: cpu_reset_in=1 during DRAIN -> state_out=0 next cycle, dma_we_out=0,
//    stall_enable_out=0.

Source files
------------

// File: rtl/trace_stall_sched_if.sv
// Bus bundle between the trace stall sequencer and its environment
// (cpu_top on the trace/stall side, dma_ctrl on the write side).
//   master : the sequencer (samples the *_in signals, drives the *_out signals)
//   slave  : the environment (drives the *_in signals, samples the *_out signals)
// Signals:
//   cpu_reset_in         CPU held in reset
//   trace_fault_in       1 = lossless mode, stall the CPU when the FIFO is full
//   iana_in              trace word from cpu_top
//   is_stall_enabled_in  CPU stall acknowledge
//   dma_writable_in      dma_ctrl FIFO has space
//   stall_enable_out     stall request to cpu_top
//   stall_disable_out    resume pulse to cpu_top
//   dma_data_out         registered trace word to dma_ctrl
//   dma_we_out           write strobe to dma_ctrl
//   state_out            sequencer state, for debug/LED
//   drop_count_out       saturating count of words lost while the FIFO was full
//   stall_count_out      saturating count of stall episodes
interface trace_stall_sched_if #(
   parameter int DATA_W = 128
);
   logic              cpu_reset_in;
   logic              trace_fault_in;
   logic [DATA_W-1:0] iana_in;
   logic              is_stall_enabled_in;
   logic              dma_writable_in;
   logic              stall_enable_out;
   logic              stall_disable_out;
   logic [DATA_W-1:0] dma_data_out;
   logic              dma_we_out;
   logic [2:0]        state_out;
   logic [15:0]       drop_count_out;
   logic [15:0]       stall_count_out;

   modport master (
      input  cpu_reset_in, trace_fault_in, iana_in, is_stall_enabled_in, dma_writable_in,
      output stall_enable_out, stall_disable_out, dma_data_out, dma_we_out,
             state_out, drop_count_out, stall_count_out
   );

   modport slave (
      output cpu_reset_in, trace_fault_in, iana_in, is_stall_enabled_in, dma_writable_in,
      input  stall_enable_out, stall_disable_out, dma_data_out, dma_we_out,
             state_out, drop_count_out, stall_count_out
   );
endinterface

// File: rtl/trace_stall_sched.sv
// Trace datapath sequencer between cpu_top and dma_ctrl. Registers the trace word,
// generates the DMA write strobe, and throttles the CPU with stall_enable/stall_disable
// whenever dma_ctrl reports no space while lossless tracing is selected.
// Ports:
//   clk     in  CPU clock, all logic on posedge
//   nreset  in  asynchronous active-low reset
//   bus     trace_stall_sched_if.master (see interface file for the signal list)
module trace_stall_sched #(
   parameter int DATA_W         = 128,
   parameter int DRAIN_CYCLES   = 3,
   parameter int RESUME_PULSE   = 2,
   parameter int RESUME_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      nreset,
   trace_stall_sched_if.master       bus
);

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_STALL  = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESUME = 3'd4
   } state_t;

   localparam logic [7:0]  LP_DRAIN = 8'(DRAIN_CYCLES);
   localparam logic [7:0]  LP_PULSE = 8'(RESUME_PULSE);
   // Timeout counts from the first cycle of a pulse, so the next pulse starts
   // exactly RESUME_TIMEOUT cycles after the previous one started.
   localparam logic [15:0] LP_TMO   = 16'(RESUME_TIMEOUT - 1);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_drain_cnt, w_drain_nxt;
   logic [7:0]        r_pulse_cnt, w_pulse_nxt;
   logic [15:0]       r_tmo_cnt,   w_tmo_nxt;
   logic              w_episode;
   logic              w_stall_en;
   logic              w_stall_dis;
   logic [DATA_W-1:0] r_dma_data_p1;
   logic              r_vld_p1;
   logic [15:0]       r_drop_cnt;
   logic [15:0]       r_stall_cnt;

   // ---- next-state / output decode
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      w_pulse_nxt = r_pulse_cnt;
      w_tmo_nxt   = r_tmo_cnt;
      w_episode   = 1'b0;
      if (bus.cpu_reset_in) begin
         w_state_nxt = ST_RUN;
         w_drain_nxt = 8'd0;
         w_pulse_nxt = 8'd0;
         w_tmo_nxt   = 16'd0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (bus.trace_fault_in && !bus.dma_writable_in) begin
                  w_state_nxt = ST_STALL;
                  w_episode   = 1'b1;
               end
            end
            ST_STALL: begin
               if (bus.is_stall_enabled_in) begin
                  w_state_nxt = ST_DRAIN;
                  w_drain_nxt = LP_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Leaving on the last count keeps DRAIN exactly DRAIN_CYCLES long.
               if (r_drain_cnt <= 8'd1) begin
                  w_state_nxt = ST_WAIT;
                  w_drain_nxt = 8'd0;
               end else begin
                  w_drain_nxt = r_drain_cnt - 8'd1;
               end
            end
            ST_WAIT: begin
               if (bus.dma_writable_in) begin
                  w_state_nxt = ST_RESUME;
                  w_pulse_nxt = LP_PULSE;
                  w_tmo_nxt   = LP_TMO;
               end
            end
            ST_RESUME: begin
               if (r_pulse_cnt != 8'd0) begin
                  w_pulse_nxt = r_pulse_cnt - 8'd1;
                  if (r_tmo_cnt != 16'd0) w_tmo_nxt = r_tmo_cnt - 16'd1;
               end else if (!bus.is_stall_enabled_in) begin
                  w_state_nxt = ST_RUN;
               end else if (r_tmo_cnt == 16'd0) begin
                  // CPU missed the resume pulse: send another one.
                  w_pulse_nxt = LP_PULSE;
                  w_tmo_nxt   = LP_TMO;
               end else begin
                  w_tmo_nxt = r_tmo_cnt - 16'd1;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
      // Both requests are masked while the CPU is held in reset; they decode from
      // disjoint states so they can never be high together.
      w_stall_en  = ((r_state == ST_STALL) || (r_state == ST_DRAIN) || (r_state == ST_WAIT))
                    && !bus.cpu_reset_in;
      w_stall_dis = (r_state == ST_RESUME) && (r_pulse_cnt != 8'd0) && !bus.cpu_reset_in;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 8'd0;
         r_pulse_cnt <= 8'd0;
         r_tmo_cnt   <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_pulse_cnt <= w_pulse_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
         if (w_episode) r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   // ---- p1: registered trace word and write intent
   // The drain term looks at the next state so the strobe stays continuous from the
   // CPU acknowledge through the whole drain window.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_dma_data_p1 <= '0;
         r_vld_p1      <= 1'b0;
         r_drop_cnt    <= 16'd0;
      end else begin
         r_dma_data_p1 <= bus.iana_in;
         r_vld_p1      <= !bus.is_stall_enabled_in
                          || ((w_state_nxt == ST_DRAIN) && !bus.cpu_reset_in);
         if (r_vld_p1 && !bus.dma_writable_in) r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   assign bus.dma_data_out      = r_dma_data_p1;
   assign bus.dma_we_out        = r_vld_p1 & bus.dma_writable_in;
   assign bus.stall_enable_out  = w_stall_en;
   assign bus.stall_disable_out = w_stall_dis;
   assign bus.state_out         = r_state;
   assign bus.drop_count_out    = r_drop_cnt;
   assign bus.stall_count_out   = r_stall_cnt;

endmodule

// File: tb/tb_trace_stall_sched.sv
module tb_trace_stall_sched;

   logic clk    = 1'b0;
   logic nreset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   trace_stall_sched_if #(.DATA_W(128)) bus ();

   trace_stall_sched #(
      .DATA_W(128), .DRAIN_CYCLES(3), .RESUME_PULSE(2), .RESUME_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .nreset(nreset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.cpu_reset_in        = 1'b0;
      bus.trace_fault_in      = 1'b0;
      bus.iana_in             = '0;
      bus.is_stall_enabled_in = 1'b0;
      bus.dma_writable_in     = 1'b1;
      nreset = 1'b0;
      tick();
      tick();
      nreset = 1'b1;
      tick();
   endtask

   // Lossless backpressure episode, returning on the first resume-pulse cycle.
   task automatic drive_to_resume();
      apply_reset();
      bus.trace_fault_in = 1'b1;
      tick();
      bus.dma_writable_in = 1'b0;
      tick();
      bus.is_stall_enabled_in = 1'b1;
      bus.dma_writable_in     = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      bus.cpu_reset_in        = 1'b0;
      bus.trace_fault_in      = 1'b0;
      bus.iana_in             = '0;
      bus.is_stall_enabled_in = 1'b0;
      bus.dma_writable_in     = 1'b1;
      #1 nreset = 1'b0;
      #1;
      n_checks++;
      if (bus.state_out !== 3'd0 || bus.dma_we_out !== 1'b0 || bus.stall_enable_out !== 1'b0) begin
         n_errors++;
         $display("FAIL por_outputs: state=%0d we=%0b sen=%0b required 0/0/0",
                  bus.state_out, bus.dma_we_out, bus.stall_enable_out);
      end
      tick();
      nreset = 1'b1;
      drive_to_resume();
      n_checks++;
      if (bus.state_out !== 3'd4 || bus.stall_disable_out !== 1'b1) begin
         n_errors++;
         $display("FAIL reach_resume: state=%0d sdis=%0b required 4/1", bus.state_out, bus.stall_disable_out);
      end
      bus.iana_in = {4{32'hDEAD_BEEF}};
      tick();
      #2 nreset = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_enable_out !== 1'b0 || bus.stall_disable_out !== 1'b0 || bus.dma_we_out !== 1'b0 ||
          bus.dma_data_out !== 128'd0 || bus.state_out !== 3'd0 || bus.drop_count_out !== 16'd0 ||
          bus.stall_count_out !== 16'd0) begin
         n_errors++;
         $display("FAIL async_reset: sen=%0b sdis=%0b we=%0b data=%h state=%0d drop=%0d stalls=%0d required all 0",
                  bus.stall_enable_out, bus.stall_disable_out, bus.dma_we_out, bus.dma_data_out,
                  bus.state_out, bus.drop_count_out, bus.stall_count_out);
      end
      bus.is_stall_enabled_in = 1'b0;
      tick();
      nreset = 1'b1;
      tick();
      n_checks++;
      if (bus.state_out !== 3'd0) begin
         n_errors++;
         $display("FAIL state_after_release: actual=%0d required=0", bus.state_out);
      end
   endtask

   task automatic test_streaming();
      logic [127:0] exp_data;
      logic [127:0] prev_data;
      apply_reset();
      prev_data = '0;
      for (int k = 1; k <= 4; k++) begin
         exp_data = {4{32'hC0DE_0000 + 32'(k)}};
         bus.iana_in = exp_data;
         #1;
         if (k > 1) begin
            n_checks++;
            if (bus.dma_data_out !== prev_data) begin
               n_errors++;
               $display("FAIL stream_latency k=%0d: actual=%h required=%h", k, bus.dma_data_out, prev_data);
            end
         end
         tick();
         n_checks++;
         if (bus.dma_data_out !== exp_data || bus.dma_we_out !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_data k=%0d: data=%h we=%0b required %h/1", k, bus.dma_data_out, bus.dma_we_out, exp_data);
         end
         prev_data = exp_data;
      end
      n_checks++;
      if (bus.drop_count_out !== 16'd0) begin
         n_errors++;
         $display("FAIL stream_drop: actual=%0d required=0", bus.drop_count_out);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] we_seen;
      apply_reset();
      bus.trace_fault_in = 1'b1;
      tick();
      bus.dma_writable_in = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_enable_out !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_no_early_stall: actual=%0b required=0", bus.stall_enable_out);
      end
      tick();
      n_checks++;
      if (bus.state_out !== 3'd1 || bus.stall_enable_out !== 1'b1 || bus.stall_count_out !== 16'd1) begin
         n_errors++;
         $display("FAIL bp_stall: state=%0d sen=%0b stalls=%0d required 1/1/1",
                  bus.state_out, bus.stall_enable_out, bus.stall_count_out);
      end
      // Cycle T: CPU acknowledges and the FIFO frees up.
      bus.is_stall_enabled_in = 1'b1;
      bus.dma_writable_in     = 1'b1;
      #1;
      we_seen[0] = bus.dma_we_out;
      for (int i = 1; i <= 4; i++) begin
         tick();
         we_seen[i] = bus.dma_we_out;
      end
      n_checks++;
      if (we_seen !== 5'b01111) begin
         n_errors++;
         $display("FAIL bp_drain_we: actual=%b required=01111", we_seen);
      end
      n_checks++;
      if (bus.state_out !== 3'd3 || bus.stall_enable_out !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_wait: state=%0d sen=%0b required 3/1", bus.state_out, bus.stall_enable_out);
      end
      tick();
      n_checks++;
      if (bus.state_out !== 3'd4 || bus.stall_disable_out !== 1'b1 || bus.stall_enable_out !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_pulse1: state=%0d sdis=%0b sen=%0b required 4/1/0",
                  bus.state_out, bus.stall_disable_out, bus.stall_enable_out);
      end
      tick();
      n_checks++;
      if (bus.stall_disable_out !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_pulse2: actual=%0b required=1", bus.stall_disable_out);
      end
      tick();
      n_checks++;
      if (bus.stall_disable_out !== 1'b0 || bus.state_out !== 3'd4) begin
         n_errors++;
         $display("FAIL bp_pulse_end: sdis=%0b state=%0d required 0/4", bus.stall_disable_out, bus.state_out);
      end
      bus.is_stall_enabled_in = 1'b0;
      tick();
      n_checks++;
      if (bus.state_out !== 3'd0 || bus.stall_count_out !== 16'd1 || bus.drop_count_out !== 16'd1) begin
         n_errors++;
         $display("FAIL bp_back_to_run: state=%0d stalls=%0d drop=%0d required 0/1/1",
                  bus.state_out, bus.stall_count_out, bus.drop_count_out);
      end
   endtask

   task automatic test_lossy();
      int sen_hits;
      apply_reset();
      bus.trace_fault_in = 1'b0;
      tick();
      bus.dma_writable_in = 1'b0;
      sen_hits = 0;
      repeat (10) begin
         tick();
         if (bus.stall_enable_out !== 1'b0 || bus.state_out !== 3'd0) sen_hits++;
      end
      n_checks++;
      if (sen_hits != 0) begin
         n_errors++;
         $display("FAIL lossy_no_stall: cycles_stalled=%0d required=0", sen_hits);
      end
      n_checks++;
      if (bus.drop_count_out !== 16'd10) begin
         n_errors++;
         $display("FAIL lossy_drop: actual=%0d required=10", bus.drop_count_out);
      end
      bus.dma_writable_in = 1'b1;
      tick();
      n_checks++;
      if (bus.drop_count_out !== 16'd10 || bus.dma_we_out !== 1'b1) begin
         n_errors++;
         $display("FAIL lossy_recover: drop=%0d we=%0b required 10/1", bus.drop_count_out, bus.dma_we_out);
      end
   endtask

   task automatic test_timeout();
      logic [18:0] sdis_seen;
      int          overlap;
      drive_to_resume();
      overlap = 0;
      sdis_seen[0] = bus.stall_disable_out;
      for (int i = 1; i <= 18; i++) begin
         tick();
         sdis_seen[i] = bus.stall_disable_out;
         if (bus.stall_enable_out === 1'b1) overlap++;
      end
      n_checks++;
      if (sdis_seen !== 19'h30003) begin
         n_errors++;
         $display("FAIL timeout_repulse: actual=%h required=30003", sdis_seen);
      end
      n_checks++;
      if (overlap != 0 || bus.state_out !== 3'd4) begin
         n_errors++;
         $display("FAIL timeout_hold: sen_cycles=%0d state=%0d required 0/4", overlap, bus.state_out);
      end
      bus.is_stall_enabled_in = 1'b0;
      tick();
   endtask

   task automatic test_cpu_reset();
      apply_reset();
      bus.trace_fault_in = 1'b1;
      tick();
      bus.dma_writable_in = 1'b0;
      tick();
      bus.is_stall_enabled_in = 1'b1;
      tick();
      n_checks++;
      if (bus.state_out !== 3'd2) begin
         n_errors++;
         $display("FAIL cpurst_in_drain: actual=%0d required=2", bus.state_out);
      end
      bus.cpu_reset_in = 1'b1;
      tick();
      n_checks++;
      if (bus.state_out !== 3'd0 || bus.dma_we_out !== 1'b0 || bus.stall_enable_out !== 1'b0 ||
          bus.stall_count_out !== 16'd1) begin
         n_errors++;
         $display("FAIL cpurst_abort: state=%0d we=%0b sen=%0b stalls=%0d required 0/0/0/1",
                  bus.state_out, bus.dma_we_out, bus.stall_enable_out, bus.stall_count_out);
      end
      bus.cpu_reset_in        = 1'b0;
      bus.is_stall_enabled_in = 1'b0;
      bus.trace_fault_in      = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_lossy();
      test_timeout();
      test_cpu_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
